// File: rtl/bitop_arbiter.sv
// Round-robin arbiter that owns a shared flag word and applies one get/set/clear/toggle per cycle.
// Each accepted op is answered through a single registered response slot that carries the pre-op bit value.
module bitop_arbiter #(
    parameter int NUM_INPUT = 8,
    parameter int NUM_REQ   = 4,
    parameter int POS_W     = $clog2(NUM_INPUT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [POS_W*NUM_REQ-1:0]   req_pos,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_value,
    output logic                       rsp_err,
    output logic [NUM_INPUT-1:0]       flags
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0]  NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [POS_W:0] POS_LIMIT = (POS_W+1)'(NUM_INPUT);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    typedef enum logic [1:0] {
        OP_GET    = 2'b00,
        OP_SET    = 2'b01,
        OP_CLR    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    slot_state_t            state;
    slot_state_t            state_next;
    logic [ID_W-1:0]        ptr;
    logic [2*NUM_REQ-1:0]   doubled;
    logic [NUM_REQ-1:0]     rotated;
    logic [ID_W-1:0]        offset;
    logic [ID_W:0]          sum;
    logic [ID_W-1:0]        winner;
    logic                   any_valid;
    logic                   can_accept;
    logic                   accept;
    op_t                    sel_op;
    logic [POS_W-1:0]       sel_pos;
    logic                   in_range;
    logic [NUM_INPUT-1:0]   mask;
    logic                   bit_before;
    logic [NUM_INPUT-1:0]   flags_next;

    // Rotate the request vector so the search always starts at bit 0, then map back by adding ptr.
    always_comb begin
        doubled = {req_valid, req_valid} >> ptr;
        rotated = doubled[NUM_REQ-1:0];
        offset  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = ID_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        winner    = sum[ID_W-1:0];
        any_valid = |req_valid;
    end

    // Slot FSM and the grant; reset suppresses any grant in its own cycle.
    always_comb begin
        state_next = state;
        can_accept = (state == SLOT_EMPTY) || rsp_ready;
        accept     = can_accept && any_valid && !rst;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (winner == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
        case (state)
            SLOT_EMPTY: begin
                if (accept) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (accept) begin
                    state_next = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    assign rsp_valid = (state == SLOT_FULL);

    // Select the winner's op and position, then compute the updated word.
    always_comb begin
        sel_op  = OP_GET;
        sel_pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_op  = op_t'(req_op[2*i +: 2]);
                sel_pos = req_pos[POS_W*i +: POS_W];
            end
        end
        in_range   = ({1'b0, sel_pos} < POS_LIMIT);
        mask       = NUM_INPUT'(1) << sel_pos;
        bit_before = |(flags & mask);
        flags_next = flags;
        if (in_range) begin
            case (sel_op)
                OP_GET:    flags_next = flags;
                OP_SET:    flags_next = flags | mask;
                OP_CLR:    flags_next = flags & ~mask;
                OP_TOGGLE: flags_next = flags ^ mask;
                default:   flags_next = flags;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SLOT_EMPTY;
            ptr       <= '0;
            flags     <= '0;
            rsp_id    <= '0;
            rsp_value <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                flags     <= flags_next;
                rsp_id    <= winner;
                rsp_value <= in_range ? bit_before : 1'b0;
                rsp_err   <= !in_range;
                ptr       <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bitop_arbiter.sv
// Scoreboard bench for bitop_arbiter: directed ops push expected responses, monitors pop on each handshake.
// A second instance with a 6-bit word exercises the out-of-range position path.
module tb_bitop_arbiter;

    localparam logic [1:0] GET = 2'b00;
    localparam logic [1:0] SET = 2'b01;
    localparam logic [1:0] CLR = 2'b10;
    localparam logic [1:0] TOG = 2'b11;

    typedef struct packed {
        logic [1:0] id;
        logic       value;
        logic       err;
        logic [7:0] flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  a_req_valid, a_req_ready;
    logic [7:0]  a_req_op;
    logic [11:0] a_req_pos;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_value, a_rsp_err;
    logic [1:0]  a_rsp_id;
    logic [7:0]  a_flags;

    logic [3:0]  b_req_valid, b_req_ready;
    logic [7:0]  b_req_op;
    logic [11:0] b_req_pos;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_value, b_rsp_err;
    logic [1:0]  b_rsp_id;
    logic [5:0]  b_flags;

    exp_t qa[$];
    exp_t qb[$];
    exp_t a_e, b_e;
    int   compared   = 0;
    int   mismatched = 0;

    int         rr_g[5] = '{0, 1, 2, 3, 0};
    logic       rr_v[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] rr_f[5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};

    bitop_arbiter #(.NUM_INPUT(8), .NUM_REQ(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_op(a_req_op), .req_pos(a_req_pos),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_id(a_rsp_id), .rsp_value(a_rsp_value), .rsp_err(a_rsp_err),
        .flags(a_flags)
    );

    bitop_arbiter #(.NUM_INPUT(6), .NUM_REQ(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op(b_req_op), .req_pos(b_req_pos),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_value(b_rsp_value), .rsp_err(b_rsp_err),
        .flags(b_flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int inst, input int id, input logic valid,
                                 input logic [1:0] op, input logic [2:0] pos);
        if (inst == 0) begin
            a_req_valid[id]     = valid;
            a_req_op[2*id +: 2] = op;
            a_req_pos[3*id +: 3] = pos;
        end else begin
            b_req_valid[id]     = valid;
            b_req_op[2*id +: 2] = op;
            b_req_pos[3*id +: 3] = pos;
        end
    endtask

    // Raise one request, wait (bounded) for its grant, record the expected response, then drop it.
    task automatic issue(input int inst, input int id, input logic [1:0] op, input logic [2:0] pos,
                         input logic exp_val, input logic exp_err, input logic [7:0] exp_flags);
        logic granted;
        exp_t e;
        granted = 1'b0;
        applyStimulus(inst, id, 1'b1, op, pos);
        for (int c = 0; c < 20 && !granted; c++) begin
            @(negedge clk);
            granted = (inst == 0) ? a_req_ready[id] : b_req_ready[id];
        end
        checkOutput($sformatf("grant_inst%0d_req%0d", inst, id), {31'b0, granted}, 32'd1);
        if (granted) begin
            e = '{id: 2'(id), value: exp_val, err: exp_err, flags: exp_flags};
            if (inst == 0) qa.push_back(e);
            else           qb.push_back(e);
        end
        @(posedge clk); #1;
        applyStimulus(inst, id, 1'b0, op, pos);
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && a_rsp_valid && a_rsp_ready) begin
            if (qa.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL a_rsp_unexpected: got id %0d with empty scoreboard", a_rsp_id);
            end else begin
                a_e = qa.pop_front();
                checkOutput("a_rsp_id",    {30'b0, a_rsp_id},    {30'b0, a_e.id});
                checkOutput("a_rsp_value", {31'b0, a_rsp_value}, {31'b0, a_e.value});
                checkOutput("a_rsp_err",   {31'b0, a_rsp_err},   {31'b0, a_e.err});
                checkOutput("a_flags",     {24'b0, a_flags},     {24'b0, a_e.flags});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL b_rsp_unexpected: got id %0d with empty scoreboard", b_rsp_id);
            end else begin
                b_e = qb.pop_front();
                checkOutput("b_rsp_id",    {30'b0, b_rsp_id},    {30'b0, b_e.id});
                checkOutput("b_rsp_value", {31'b0, b_rsp_value}, {31'b0, b_e.value});
                checkOutput("b_rsp_err",   {31'b0, b_rsp_err},   {31'b0, b_e.err});
                checkOutput("b_flags",     {26'b0, b_flags},     {24'b0, b_e.flags});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        a_req_valid = 4'b0100;
        a_req_op    = '0;
        a_req_pos   = '0;
        a_rsp_ready = 1'b0;
        b_req_valid = '0;
        b_req_op    = '0;
        b_req_pos   = '0;
        b_rsp_ready = 1'b0;

        // Reset values, and no grant while reset is high even with a request present.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", {28'b0, a_req_ready}, 32'd0);
        checkOutput("reset_flags",     {24'b0, a_flags},     32'd0);
        checkOutput("reset_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        checkOutput("reset_rsp_id",    {30'b0, a_rsp_id},    32'd0);
        checkOutput("reset_rsp_value", {31'b0, a_rsp_value}, 32'd0);
        checkOutput("reset_rsp_err",   {31'b0, a_rsp_err},   32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        a_req_valid = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;

        // Single op then read-back.
        issue(0, 0, SET, 3'd3, 1'b0, 1'b0, 8'h08);
        issue(0, 0, GET, 3'd3, 1'b1, 1'b0, 8'h08);
        drain(2);

        // Fresh reset so round-robin starts at pointer 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) applyStimulus(0, i, 1'b1, SET, 3'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_grant_%0d", k), {28'b0, a_req_ready}, 32'd1 << rr_g[k]);
            qa.push_back('{id: 2'(rr_g[k]), value: rr_v[k], err: 1'b0, flags: rr_f[k]});
            @(posedge clk); #1;
            if (k == 0) applyStimulus(0, 0, 1'b1, GET, 3'd0);
            else        applyStimulus(0, rr_g[k], 1'b0, GET, 3'd0);
        end
        drain(1);

        // Backpressure: response held while the consumer stalls, grant reappears when it resumes.
        a_rsp_ready = 1'b0;
        applyStimulus(0, 1, 1'b1, TOG, 3'd7);
        applyStimulus(0, 2, 1'b1, SET, 3'd6);
        @(negedge clk);
        checkOutput("bp_first_grant", {28'b0, a_req_ready}, 32'b0010);
        qa.push_back('{id: 2'd1, value: 1'b0, err: 1'b0, flags: 8'h8F});
        @(posedge clk); #1;
        applyStimulus(0, 1, 1'b0, TOG, 3'd7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_req_ready",  {28'b0, a_req_ready}, 32'd0);
            checkOutput("bp_rsp_valid",  {31'b0, a_rsp_valid}, 32'd1);
            checkOutput("bp_rsp_id",     {30'b0, a_rsp_id},    32'd1);
            checkOutput("bp_rsp_value",  {31'b0, a_rsp_value}, 32'd0);
            checkOutput("bp_flags",      {24'b0, a_flags},     32'h8F);
        end
        @(posedge clk); #1;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_resume_grant", {28'b0, a_req_ready}, 32'b0100);
        qa.push_back('{id: 2'd2, value: 1'b0, err: 1'b0, flags: 8'hCF});
        @(posedge clk); #1;
        applyStimulus(0, 2, 1'b0, SET, 3'd6);

        // Walk the word to 0xA5, then cover CLR and both TOGGLE directions.
        issue(0, 3, CLR, 3'd6, 1'b1, 1'b0, 8'h8F);
        issue(0, 3, SET, 3'd5, 1'b0, 1'b0, 8'hAF);
        issue(0, 3, CLR, 3'd3, 1'b1, 1'b0, 8'hA7);
        issue(0, 3, CLR, 3'd1, 1'b1, 1'b0, 8'hA5);
        issue(0, 3, CLR, 3'd0, 1'b1, 1'b0, 8'hA4);
        issue(0, 3, TOG, 3'd1, 1'b0, 1'b0, 8'hA6);
        issue(0, 3, TOG, 3'd1, 1'b1, 1'b0, 8'hA4);

        // Build 0x3C with a response left pending, then reset mid-operation.
        issue(0, 0, CLR, 3'd7, 1'b1, 1'b0, 8'h24);
        issue(0, 0, SET, 3'd4, 1'b0, 1'b0, 8'h34);
        drain(1);
        a_rsp_ready = 1'b0;
        issue(0, 0, SET, 3'd3, 1'b0, 1'b0, 8'h3C);
        @(negedge clk);
        checkOutput("pre_rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
        checkOutput("pre_rst_flags",     {24'b0, a_flags},     32'h3C);
        @(posedge clk); #1;
        rst         = 1'b1;
        a_rsp_ready = 1'b1;
        qa.delete();
        applyStimulus(0, 0, 1'b1, GET, 3'd2);
        applyStimulus(0, 2, 1'b1, SET, 3'd0);
        @(negedge clk);
        checkOutput("rst_cycle_req_ready", {28'b0, a_req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_flags",     {24'b0, a_flags},     32'd0);
        checkOutput("post_rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        checkOutput("post_rst_grant",     {28'b0, a_req_ready}, 32'b0001);
        qa.push_back('{id: 2'd0, value: 1'b0, err: 1'b0, flags: 8'h00});
        @(posedge clk); #1;
        applyStimulus(0, 0, 1'b0, GET, 3'd2);
        @(negedge clk);
        checkOutput("post_rst_grant2", {28'b0, a_req_ready}, 32'b0100);
        qa.push_back('{id: 2'd2, value: 1'b0, err: 1'b0, flags: 8'h01});
        @(posedge clk); #1;
        applyStimulus(0, 2, 1'b0, SET, 3'd0);
        drain(2);

        // 6-bit word: out-of-range position errors out, keeps flags, still advances the pointer.
        issue(1, 0, SET, 3'd2, 1'b0, 1'b0, 8'h04);
        issue(1, 1, SET, 3'd7, 1'b0, 1'b1, 8'h04);
        applyStimulus(1, 1, 1'b1, GET, 3'd2);
        applyStimulus(1, 3, 1'b1, TOG, 3'd5);
        @(negedge clk);
        checkOutput("b_ptr_after_err_grant", {28'b0, b_req_ready}, 32'b1000);
        qb.push_back('{id: 2'd3, value: 1'b0, err: 1'b0, flags: 8'h24});
        @(posedge clk); #1;
        applyStimulus(1, 3, 1'b0, TOG, 3'd5);
        @(negedge clk);
        checkOutput("b_second_grant", {28'b0, b_req_ready}, 32'b0010);
        qb.push_back('{id: 2'd1, value: 1'b1, err: 1'b0, flags: 8'h24});
        @(posedge clk); #1;
        applyStimulus(1, 1, 1'b0, GET, 3'd2);
        drain(3);

        checkOutput("a_scoreboard_empty", qa.size(), 32'd0);
        checkOutput("b_scoreboard_empty", qb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
